// File: rtl/pipe_ctrl.sv
// Five-stage LC-3b pipeline sequencing: per-stage load/flush controls from memory handshakes,
// load-use hazards and MEM-resolved branches. Optional counters behind PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_imem_resp,
  input  logic       i_dmem_req,
  input  logic       i_dmem_resp,
  input  logic       i_br_taken,
  input  logic [3:0] i_id_opcode,
  input  logic [2:0] i_id_dest,
  input  logic [2:0] i_id_src1,
  input  logic [2:0] i_id_src2,
  input  logic       i_id_ir11,
  input  logic       i_id_ir5,
  input  logic       i_ex_mem_read,
  input  logic [2:0] i_ex_dest,
  output logic       o_load_pc,
  output logic       o_load_if_id,
  output logic       o_load_id_ex,
  output logic       o_load_ex_mem,
  output logic       o_load_mem_wb,
  output logic       o_flush_if_id,
  output logic       o_flush_id_ex,
  output logic       o_flush_ex_mem,
  output logic       o_imem_read
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] o_stall_cycles,
  output logic [15:0] o_flush_events
`endif
);

  typedef enum logic [1:0] {StInit, StRun, StDstall, StRedirect} state_e;

  state_e r_state;
  state_e w_state_d;

  logic w_use_src1;
  logic w_use_src2;
  logic w_use_dest;
  logic w_load_use;
  logic w_active;
  logic w_dstall;
  logic w_redirect;

  // Register fields that the ID instruction actually reads.
  always_comb begin
    w_use_src1 = 1'b0;
    w_use_src2 = 1'b0;
    w_use_dest = 1'b0;
    unique case (i_id_opcode)
      4'b0001, 4'b0101: begin
        w_use_src1 = 1'b1;
        w_use_src2 = !i_id_ir5;
      end
      4'b1001, 4'b1101, 4'b0110, 4'b0010, 4'b1010, 4'b1100: w_use_src1 = 1'b1;
      4'b0111, 4'b0011, 4'b1011: begin
        w_use_src1 = 1'b1;
        w_use_dest = 1'b1;
      end
      4'b0100: w_use_src1 = !i_id_ir11;
      default: ;
    endcase
  end

  assign w_load_use = i_ex_mem_read &&
                      ((w_use_src1 && (i_ex_dest == i_id_src1)) ||
                       (w_use_src2 && (i_ex_dest == i_id_src2)) ||
                       (w_use_dest && (i_ex_dest == i_id_dest)));

  assign w_active   = !i_reset && ((r_state == StRun) || (r_state == StDstall));
  // In DSTALL the request is already outstanding; only the response releases it.
  assign w_dstall   = w_active && !i_dmem_resp && ((r_state == StDstall) || i_dmem_req);
  assign w_redirect = w_active && !w_dstall && i_br_taken;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StInit;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StInit:     w_state_d = StRun;
      StRun, StDstall: begin
        if (w_dstall)        w_state_d = StDstall;
        else if (w_redirect) w_state_d = StRedirect;
        else                 w_state_d = StRun;
      end
      StRedirect: w_state_d = StRun;
      default:    w_state_d = StInit;
    endcase
  end

  always_comb begin
    o_load_pc      = 1'b1;
    o_load_if_id   = 1'b1;
    o_load_id_ex   = 1'b1;
    o_load_ex_mem  = 1'b1;
    o_load_mem_wb  = 1'b1;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    o_flush_ex_mem = 1'b0;
    o_imem_read    = 1'b1;
    if (i_reset || (r_state == StInit)) begin
      o_load_pc      = 1'b0;
      o_flush_if_id  = 1'b1;
      o_flush_id_ex  = 1'b1;
      o_flush_ex_mem = 1'b1;
      o_imem_read    = 1'b0;
    end else if (r_state == StRedirect) begin
      o_load_pc     = 1'b0;
      o_flush_if_id = 1'b1;
      o_imem_read   = 1'b0;
    end else if (w_dstall) begin
      o_load_pc     = 1'b0;
      o_load_if_id  = 1'b0;
      o_load_id_ex  = 1'b0;
      o_load_ex_mem = 1'b0;
      o_load_mem_wb = 1'b0;
    end else if (w_redirect) begin
      o_flush_if_id  = 1'b1;
      o_flush_id_ex  = 1'b1;
      o_flush_ex_mem = 1'b1;
    end else if (w_load_use) begin
      o_load_pc     = 1'b0;
      o_load_if_id  = 1'b0;
      o_flush_id_ex = 1'b1;
    end else if (!i_imem_resp) begin
      o_load_pc     = 1'b0;
      o_flush_if_id = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if ((r_state != StInit) && !o_load_pc && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_redirect && (r_flush_events != 16'hFFFF)) begin
        r_flush_events <= r_flush_events + 16'd1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counter checks run when PIPE_CTRL_PERF_EN is set.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset, imem_resp, dmem_req, dmem_resp, br_taken;
  logic [3:0] id_opcode;
  logic [2:0] id_dest, id_src1, id_src2, ex_dest;
  logic       id_ir11, id_ir5, ex_mem_read;
  logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem, imem_read;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  int total = 0;
  int bad   = 0;

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id/id_ex/ex_mem, imem_read}
  localparam logic [8:0] OutInit  = 9'b0_1111_111_0;
  localparam logic [8:0] OutRun   = 9'b1_1111_000_1;
  localparam logic [8:0] OutDst   = 9'b0_0000_000_1;
  localparam logic [8:0] OutRedGo = 9'b1_1111_111_1;
  localparam logic [8:0] OutLu    = 9'b0_0111_010_1;
  localparam logic [8:0] OutFetch = 9'b0_1111_100_1;
  localparam logic [8:0] OutRedSt = 9'b0_1111_100_0;

  logic [8:0] outs;
  assign outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                 flush_if_id, flush_id_ex, flush_ex_mem, imem_read};

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_imem_resp   (imem_resp),
    .i_dmem_req    (dmem_req),
    .i_dmem_resp   (dmem_resp),
    .i_br_taken    (br_taken),
    .i_id_opcode   (id_opcode),
    .i_id_dest     (id_dest),
    .i_id_src1     (id_src1),
    .i_id_src2     (id_src2),
    .i_id_ir11     (id_ir11),
    .i_id_ir5      (id_ir5),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_dest     (ex_dest),
    .o_load_pc     (load_pc),
    .o_load_if_id  (load_if_id),
    .o_load_id_ex  (load_id_ex),
    .o_load_ex_mem (load_ex_mem),
    .o_load_mem_wb (load_mem_wb),
    .o_flush_if_id (flush_if_id),
    .o_flush_id_ex (flush_id_ex),
    .o_flush_ex_mem(flush_ex_mem),
    .o_imem_read   (imem_read)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_stall_cycles(stall_cycles),
    .o_flush_events(flush_events)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic ir11, input logic ir5);
    id_opcode = op;
    id_dest   = d;
    id_src1   = s1;
    id_src2   = s2;
    id_ir11   = ir11;
    id_ir5    = ir5;
  endtask

  initial begin
    reset = 1'b1; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0; br_taken = 1'b0;
    ex_mem_read = 1'b0; ex_dest = 3'd0;
    set_id(4'b0000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // Reset held two cycles, one INIT cycle, then RUN
    #1 chk("rst_a", 16'(outs), 16'(OutInit));
    cyc(); chk("rst_b", 16'(outs), 16'(OutInit));
    cyc(); reset = 1'b0; #1 chk("init", 16'(outs), 16'(OutInit));
    cyc(); chk("run", 16'(outs), 16'(OutRun));

    // LDR R3 in EX, ADD R1,R3,R2 in ID: one bubble
    ex_mem_read = 1'b1; ex_dest = 3'd3;
    set_id(4'b0001, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0);
    #1 chk("lu_add_src1", 16'(outs), 16'(OutLu));
    cyc(); ex_mem_read = 1'b0; #1 chk("lu_release", 16'(outs), 16'(OutRun));
    ex_mem_read = 1'b1;
    set_id(4'b0001, 3'd1, 3'd1, 3'd3, 1'b0, 1'b1);
    #1 chk("add_imm_no_lu", 16'(outs), 16'(OutRun));
    set_id(4'b0101, 3'd1, 3'd1, 3'd3, 1'b0, 1'b0);
    #1 chk("lu_and_src2", 16'(outs), 16'(OutLu));
    set_id(4'b0111, 3'd3, 3'd5, 3'd0, 1'b0, 1'b0);
    #1 chk("lu_str_dest", 16'(outs), 16'(OutLu));
    set_id(4'b0100, 3'd0, 3'd3, 3'd0, 1'b1, 1'b0);
    #1 chk("jsr_imm_no_lu", 16'(outs), 16'(OutRun));
    set_id(4'b0100, 3'd0, 3'd3, 3'd0, 1'b0, 1'b0);
    #1 chk("lu_jsrr", 16'(outs), 16'(OutLu));
    set_id(4'b0000, 3'd3, 3'd3, 3'd3, 1'b1, 1'b0);
    #1 chk("br_no_lu", 16'(outs), 16'(OutRun));
    ex_mem_read = 1'b0;

    // Data stall for 4 cycles; br_taken during the stall is held off
    dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      br_taken = (i == 2);
      #1 chk($sformatf("dstall_%0d", i), 16'(outs), 16'(OutDst));
      cyc();
    end
    br_taken = 1'b0; dmem_resp = 1'b1;
    #1 chk("dstall_release", 16'(outs), 16'(OutRun));
    cyc(); dmem_req = 1'b0; dmem_resp = 1'b0;
    #1 chk("after_release", 16'(outs), 16'(OutRun));

    // Stall released together with a taken branch
    dmem_req = 1'b1; cyc();
    #1 chk("dstall_b", 16'(outs), 16'(OutDst));
    dmem_resp = 1'b1; br_taken = 1'b1;
    #1 chk("release_redirect", 16'(outs), 16'(OutRedGo));
    cyc(); dmem_req = 1'b0; dmem_resp = 1'b0; br_taken = 1'b0;
    #1 chk("redirect_st_a", 16'(outs), 16'(OutRedSt));
    cyc(); chk("redirect_done_a", 16'(outs), 16'(OutRun));

    // Taken branch with simultaneous load-use: redirect wins
    ex_mem_read = 1'b1; ex_dest = 3'd3;
    set_id(4'b0001, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0);
    br_taken = 1'b1;
    #1 chk("br_over_lu", 16'(outs), 16'(OutRedGo));
    cyc(); br_taken = 1'b0; ex_mem_read = 1'b0;
    #1 chk("redirect_st_b", 16'(outs), 16'(OutRedSt));
    cyc(); chk("redirect_done_b", 16'(outs), 16'(OutRun));

    // Fetch stall for 3 cycles
    imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("fetch_%0d", i), 16'(outs), 16'(OutFetch));
      cyc();
    end
    imem_resp = 1'b1;
    #1 chk("fetch_done", 16'(outs), 16'(OutRun));

    // Data stall beats fetch stall; reset mid-stall takes effect at once
    dmem_req = 1'b1; imem_resp = 1'b0;
    #1 chk("dstall_over_fetch", 16'(outs), 16'(OutDst));
    cyc(); imem_resp = 1'b1;
    #1 chk("dstall_c", 16'(outs), 16'(OutDst));
    reset = 1'b1;
    #1 chk("reset_mid_stall", 16'(outs), 16'(OutInit));
    cyc(); reset = 1'b0; dmem_req = 1'b0;
    #1 chk("init_after_stall", 16'(outs), 16'(OutInit));
    cyc(); chk("run_after_stall", 16'(outs), 16'(OutRun));

`ifdef PIPE_CTRL_PERF_EN
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    for (int i = 0; i < 2; i++) begin
      br_taken = 1'b1; cyc();
      br_taken = 1'b0; cyc();
    end
    chk("perf_flush_2", flush_events, 16'd2);
    chk("perf_stall_2", stall_cycles, 16'd2);
    dmem_req = 1'b1;
    repeat (70000) cyc();
    chk("perf_stall_sat", stall_cycles, 16'hFFFF);
    dmem_req = 1'b0; reset = 1'b1; cyc();
    chk("perf_stall_clr", stall_cycles, 16'd0);
    chk("perf_flush_clr", flush_events, 16'd0);
    reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
